// File: rtl/bus_arb_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb_pkg
//   Shared types and constants for the basil register-bus master arbiter.
//   Contents:
//     arb_state_e  - arbiter FSM states (IDLE / GRANT / RELEASE)
//     BUS_AW       - bus address width
//     BUS_DW       - bus data width
//     MAX_MASTERS  - largest supported number of bus masters
//     OWNER_W      - width of a master index (OWNER output, RR pointer)
// ----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int BUS_AW      = 32;
    localparam int BUS_DW      = 32;
    localparam int MAX_MASTERS = 4;
    localparam int OWNER_W     = $clog2(MAX_MASTERS);

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first requester found when
//   scanning upward from the pointer, wrapping past the top master.
//   Ports:
//     req_i  in   N_MASTERS  request vector
//     ptr_i  in   OWNER_W    index of the highest-priority master
//     gnt_o  out  N_MASTERS  one-hot winner (all zero when no request)
//     idx_o  out  OWNER_W    index of the winner
//     any_o  out  1          at least one request present
// ----------------------------------------------------------------------------
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [OWNER_W-1:0]   ptr_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [OWNER_W-1:0]   idx_o,
    output logic                 any_o
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [IW-1:0] cand;

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = IW'((int'(ptr_i) + k) % N_MASTERS);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = OWNER_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// ----------------------------------------------------------------------------
// bus_master_arbiter
//   Shares the basil register bus between N_MASTERS masters. Round-robin
//   arbitration with ownership held for as long as M_REQ stays high, a
//   turnaround gap on every handover, read data routed back to the issuing
//   master, and a hold-time watchdog that forces a release.
//   Ports:
//     BUS_CLK / BUS_RST_N    clock, async active-low reset
//     M_REQ / M_GNT          per-master request, one-hot grant
//     M_ADD / M_DATA_WR      per-master address / write data (32 bits each)
//     M_RD / M_WR            per-master single-cycle strobes
//     M_DATA_RD / M_RD_VALID returned read data and one-hot valid
//     BUS_ADD / BUS_DATA_OUT bus address / write data
//     BUS_DATA_IN            bus read data
//     BUS_RD / BUS_WR        bus strobes
//     OWNER                  index of current/last owner
//     TIMEOUT_ERR / _CLR     sticky forced-release flag and its clear
// ----------------------------------------------------------------------------
module bus_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 4096
) (
    input  logic                          BUS_CLK,
    input  logic                          BUS_RST_N,
    input  logic [N_MASTERS-1:0]          M_REQ,
    output logic [N_MASTERS-1:0]          M_GNT,
    input  logic [BUS_AW*N_MASTERS-1:0]   M_ADD,
    input  logic [BUS_DW*N_MASTERS-1:0]   M_DATA_WR,
    input  logic [N_MASTERS-1:0]          M_RD,
    input  logic [N_MASTERS-1:0]          M_WR,
    output logic [BUS_DW-1:0]             M_DATA_RD,
    output logic [N_MASTERS-1:0]          M_RD_VALID,
    output logic [BUS_AW-1:0]             BUS_ADD,
    output logic [BUS_DW-1:0]             BUS_DATA_OUT,
    input  logic [BUS_DW-1:0]             BUS_DATA_IN,
    output logic                          BUS_RD,
    output logic                          BUS_WR,
    output logic [OWNER_W-1:0]            OWNER,
    output logic                          TIMEOUT_ERR,
    input  logic                          TIMEOUT_CLR
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    arb_state_e                state_q, state_d;
    logic [N_MASTERS-1:0]      gnt_q, gnt_d;
    logic [OWNER_W-1:0]        owner_q, owner_d;
    logic [OWNER_W-1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0]         holdCnt_q, holdCnt_d;
    logic [1:0]                relCnt_q, relCnt_d;
    logic                      timeoutErr_q, timeoutErr_d;
    logic [BUS_AW-1:0]         busAdd_q, busAdd_d;
    logic [BUS_DW-1:0]         busData_q, busData_d;
    logic                      busRd_q, busRd_d;
    logic                      busWr_q, busWr_d;
    logic [RD_LATENCY:0]       tagVld_q;
    logic [OWNER_W-1:0]        tagIdx_q [RD_LATENCY+1];
    logic [N_MASTERS-1:0]      rdValid_q, rdValid_d;
    logic [BUS_DW-1:0]         dataRd_q, dataRd_d;

    logic [N_MASTERS-1:0]      pickGnt;
    logic [OWNER_W-1:0]        pickIdx;
    logic                      pickAny;

    logic                      ownReq, ownRd, ownWr;
    logic [BUS_AW-1:0]         ownAdd;
    logic [BUS_DW-1:0]         ownData;
    logic                      holdHit;

    rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
        .req_i (M_REQ),
        .ptr_i (ptr_q),
        .gnt_o (pickGnt),
        .idx_o (pickIdx),
        .any_o (pickAny)
    );

    // Owner mux driven by the one-hot grant, so non-granted strobes never leak.
    always_comb begin
        ownReq  = 1'b0;
        ownRd   = 1'b0;
        ownWr   = 1'b0;
        ownAdd  = '0;
        ownData = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_q[i]) begin
                ownReq  = M_REQ[i];
                ownRd   = M_RD[i];
                ownWr   = M_WR[i];
                ownAdd  = M_ADD[BUS_AW*i +: BUS_AW];
                ownData = M_DATA_WR[BUS_DW*i +: BUS_DW];
            end
        end
    end

    assign holdHit = (MAX_HOLD != 0) && (holdCnt_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        holdCnt_d    = holdCnt_q;
        relCnt_d     = relCnt_q;
        timeoutErr_d = timeoutErr_q & ~TIMEOUT_CLR;
        busAdd_d     = busAdd_q;
        busData_d    = busData_q;
        busRd_d      = 1'b0;
        busWr_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pickAny) begin
                    gnt_d     = pickGnt;
                    owner_d   = pickIdx;
                    holdCnt_d = '0;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A write beats a simultaneous read; the read is dropped.
                busWr_d = ownWr;
                busRd_d = ownRd & ~ownWr;
                if (ownRd || ownWr) begin
                    busAdd_d = ownAdd;
                end
                if (ownWr) begin
                    busData_d = ownData;
                end
                if (holdCnt_q != '1) begin
                    holdCnt_d = holdCnt_q + HOLD_W'(1);
                end
                // Releasing owner moves to lowest priority via pointer = owner+1.
                if (!ownReq || holdHit) begin
                    gnt_d    = '0;
                    ptr_d    = OWNER_W'((int'(owner_q) + 1) % N_MASTERS);
                    relCnt_d = '0;
                    state_d  = ST_RELEASE;
                    if (ownReq) begin
                        timeoutErr_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                // RD_LATENCY+1 quiet cycles so the last read drains before handover.
                if (relCnt_q == 2'(RD_LATENCY)) begin
                    state_d = ST_IDLE;
                end else begin
                    relCnt_d = relCnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read return: the tag emerging from the pipe selects which master sees valid.
    always_comb begin
        rdValid_d = '0;
        dataRd_d  = dataRd_q;
        if (tagVld_q[RD_LATENCY]) begin
            dataRd_d = BUS_DATA_IN;
            for (int i = 0; i < N_MASTERS; i++) begin
                rdValid_d[i] = (tagIdx_q[RD_LATENCY] == OWNER_W'(i));
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            holdCnt_q    <= '0;
            relCnt_q     <= '0;
            timeoutErr_q <= 1'b0;
            busAdd_q     <= '0;
            busData_q    <= '0;
            busRd_q      <= 1'b0;
            busWr_q      <= 1'b0;
            rdValid_q    <= '0;
            dataRd_q     <= '0;
            tagVld_q     <= '0;
            for (int s = 0; s <= RD_LATENCY; s++) begin
                tagIdx_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            holdCnt_q    <= holdCnt_d;
            relCnt_q     <= relCnt_d;
            timeoutErr_q <= timeoutErr_d;
            busAdd_q     <= busAdd_d;
            busData_q    <= busData_d;
            busRd_q      <= busRd_d;
            busWr_q      <= busWr_d;
            rdValid_q    <= rdValid_d;
            dataRd_q     <= dataRd_d;
            tagVld_q[0]  <= busRd_d;
            tagIdx_q[0]  <= owner_q;
            for (int s = 1; s <= RD_LATENCY; s++) begin
                tagVld_q[s] <= tagVld_q[s-1];
                tagIdx_q[s] <= tagIdx_q[s-1];
            end
        end
    end

    assign M_GNT        = gnt_q;
    assign OWNER        = owner_q;
    assign TIMEOUT_ERR  = timeoutErr_q;
    assign BUS_ADD      = busAdd_q;
    assign BUS_DATA_OUT = busData_q;
    assign BUS_RD       = busRd_q;
    assign BUS_WR       = busWr_q;
    assign M_RD_VALID   = rdValid_q;
    assign M_DATA_RD    = dataRd_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_master_arbiter
//   Directed bench for bus_master_arbiter. Two instances share all inputs:
//   dutA (RD_LATENCY=1, MAX_HOLD=8) and dutB (RD_LATENCY=2, MAX_HOLD=4096).
// ----------------------------------------------------------------------------
module tb_bus_master_arbiter;

    logic        clk;
    logic        rstN;
    logic [1:0]  mReq;
    logic [63:0] mAdd;
    logic [63:0] mDataWr;
    logic [1:0]  mRd;
    logic [1:0]  mWr;
    logic [31:0] busDataIn;
    logic        timeoutClr;

    logic [1:0]  aGnt, aRdValid, aOwner;
    logic [31:0] aDataRd, aBusAdd, aBusDataOut;
    logic        aBusRd, aBusWr, aTimeoutErr;

    logic [1:0]  bGnt, bRdValid, bOwner;
    logic [31:0] bDataRd, bBusAdd, bBusDataOut;
    logic        bBusRd, bBusWr, bTimeoutErr;

    int checkCount = 0;
    int failCount  = 0;

    bus_master_arbiter #(.N_MASTERS(2), .RD_LATENCY(1), .MAX_HOLD(8)) dutA (
        .BUS_CLK(clk), .BUS_RST_N(rstN), .M_REQ(mReq), .M_GNT(aGnt),
        .M_ADD(mAdd), .M_DATA_WR(mDataWr), .M_RD(mRd), .M_WR(mWr),
        .M_DATA_RD(aDataRd), .M_RD_VALID(aRdValid), .BUS_ADD(aBusAdd),
        .BUS_DATA_OUT(aBusDataOut), .BUS_DATA_IN(busDataIn), .BUS_RD(aBusRd),
        .BUS_WR(aBusWr), .OWNER(aOwner), .TIMEOUT_ERR(aTimeoutErr),
        .TIMEOUT_CLR(timeoutClr)
    );

    bus_master_arbiter #(.N_MASTERS(2), .RD_LATENCY(2), .MAX_HOLD(4096)) dutB (
        .BUS_CLK(clk), .BUS_RST_N(rstN), .M_REQ(mReq), .M_GNT(bGnt),
        .M_ADD(mAdd), .M_DATA_WR(mDataWr), .M_RD(mRd), .M_WR(mWr),
        .M_DATA_RD(bDataRd), .M_RD_VALID(bRdValid), .BUS_ADD(bBusAdd),
        .BUS_DATA_OUT(bBusDataOut), .BUS_DATA_IN(busDataIn), .BUS_RD(bBusRd),
        .BUS_WR(bBusWr), .OWNER(bOwner), .TIMEOUT_ERR(bTimeoutErr),
        .TIMEOUT_CLR(timeoutClr)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive request/strobe vectors, then advance one edge and settle 1ns past it.
    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rd,
                                 input logic [1:0] wr);
        mReq = req;
        mRd  = rd;
        mWr  = wr;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, verify the reset state, then release mid-cycle.
    task automatic doReset();
        rstN       = 1'b0;
        mReq       = '0;
        mRd        = '0;
        mWr        = '0;
        mAdd       = '0;
        mDataWr    = '0;
        busDataIn  = '0;
        timeoutClr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt",     32'(aGnt),        32'h0);
        checkOutput("rst_owner",   32'(aOwner),      32'h0);
        checkOutput("rst_timeout", 32'(aTimeoutErr), 32'h0);
        checkOutput("rst_rdvalid", 32'(bRdValid),    32'h0);
        checkOutput("rst_busdata", bBusDataOut,      32'h0);
        checkOutput("rst_b_owner", 32'(bOwner),      32'h0);
        checkOutput("rst_b_to",    32'(bTimeoutErr), 32'h0);
        rstN = 1'b1;
    endtask

    // Safety net: the directed sequence is short, so this only fires on a hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    // Directed scenarios in order: write, round-robin, read return, non-owner,
    // watchdog and mid-burst reset.
    initial begin
        // Single write from M0, plus non-owner strobe and RD+WR collision.
        doReset();
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("t1_gnt",   32'(aGnt),   32'h1);
        checkOutput("t1_owner", 32'(aOwner), 32'h0);
        mAdd[31:0] = 32'h10; mDataWr[31:0] = 32'hA5;
        applyStimulus(2'b01, 2'b00, 2'b01);
        checkOutput("t1_wr",    32'(aBusWr), 32'h1);
        checkOutput("t1_rd",    32'(aBusRd), 32'h0);
        checkOutput("t1_add",   aBusAdd,     32'h10);
        checkOutput("t1_data",  aBusDataOut, 32'hA5);
        mAdd[63:32] = 32'h99; mDataWr[63:32] = 32'h77;
        applyStimulus(2'b01, 2'b00, 2'b10);
        checkOutput("t4_wr",    32'(aBusWr), 32'h0);
        checkOutput("t4_add",   aBusAdd,     32'h10);
        checkOutput("t4_data",  aBusDataOut, 32'hA5);
        mAdd[31:0] = 32'h14; mDataWr[31:0] = 32'h5A;
        applyStimulus(2'b01, 2'b01, 2'b01);
        checkOutput("rdwr_wr",  32'(aBusWr), 32'h1);
        checkOutput("rdwr_rd",  32'(aBusRd), 32'h0);
        checkOutput("rdwr_add", aBusAdd,     32'h14);
        mAdd[31:0] = 32'h18;
        applyStimulus(2'b01, 2'b01, 2'b00);
        checkOutput("a_rd",     32'(aBusRd), 32'h1);
        checkOutput("a_rd_add", aBusAdd,     32'h18);
        checkOutput("a_rd_dat", aBusDataOut, 32'h5A);
        busDataIn = 32'h0BADF00D;
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("a_rv_early", 32'(aRdValid), 32'h0);
        busDataIn = 32'h12345678;
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("a_rv",     32'(aRdValid), 32'h1);
        checkOutput("a_rdata",  aDataRd,       32'h12345678);
        applyStimulus(2'b00, 2'b00, 2'b00);
        checkOutput("a_rel_gnt", 32'(aGnt),       32'h0);
        checkOutput("a_rv_done", 32'(aRdValid),   32'h0);
        checkOutput("a_no_to",   32'(aTimeoutErr), 32'h0);

        // Round-robin handover with a two-cycle release gap.
        doReset();
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t2_gnt0",  32'(aGnt), 32'h1);
        applyStimulus(2'b10, 2'b00, 2'b00);
        checkOutput("t2_drop",  32'(aGnt), 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t2_rel1",  32'(aGnt), 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t2_idle",  32'(aGnt), 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t2_gnt1",  32'(aGnt),   32'h2);
        checkOutput("t2_own1",  32'(aOwner), 32'h1);
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("t2_drop1", 32'(aGnt), 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t2_idle2", 32'(aGnt), 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t2_gnt0b", 32'(aGnt),   32'h1);
        checkOutput("t2_own0",  32'(aOwner), 32'h0);

        // Read with RD_LATENCY=2 returns to M1 after its grant has ended.
        doReset();
        applyStimulus(2'b10, 2'b00, 2'b00);
        checkOutput("t3_gnt1",  32'(bGnt), 32'h2);
        mAdd[63:32] = 32'h20;
        applyStimulus(2'b01, 2'b10, 2'b00);
        checkOutput("t3_busrd", 32'(bBusRd), 32'h1);
        checkOutput("t3_add",   bBusAdd,     32'h20);
        checkOutput("t3_drop",  32'(bGnt),   32'h0);
        busDataIn = 32'h11111111;
        applyStimulus(2'b01, 2'b00, 2'b01);
        checkOutput("t3_rd_off", 32'(bBusRd),   32'h0);
        checkOutput("t3_wr_r1",  32'(bBusWr),   32'h0);
        applyStimulus(2'b01, 2'b00, 2'b01);
        checkOutput("t3_rv_pre", 32'(bRdValid), 32'h0);
        checkOutput("t3_wr_r2",  32'(bBusWr),   32'h0);
        busDataIn = 32'hCAFEF00D;
        applyStimulus(2'b01, 2'b00, 2'b01);
        checkOutput("t3_rv",     32'(bRdValid), 32'h2);
        checkOutput("t3_rdata",  bDataRd,       32'hCAFEF00D);
        checkOutput("t3_gnt_r3", 32'(bGnt),     32'h0);
        checkOutput("t3_wr_r3",  32'(bBusWr),   32'h0);
        busDataIn = 32'h22222222;
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("t3_rv_off", 32'(bRdValid), 32'h0);
        checkOutput("t3_rhold",  bDataRd,       32'hCAFEF00D);
        checkOutput("t3_gnt0",   32'(bGnt),     32'h1);

        // Watchdog with MAX_HOLD=8; clear in the expiry cycle loses to set.
        doReset();
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t5_gnt0", 32'(aGnt), 32'h1);
        repeat (6) applyStimulus(2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t5_hold8", 32'(aGnt),        32'h1);
        checkOutput("t5_to_pre", 32'(aTimeoutErr), 32'h0);
        timeoutClr = 1'b1;
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t5_forced", 32'(aGnt),        32'h0);
        checkOutput("t5_to_set", 32'(aTimeoutErr), 32'h1);
        timeoutClr = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t5_sticky", 32'(aTimeoutErr), 32'h1);
        timeoutClr = 1'b1;
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t5_to_clr", 32'(aTimeoutErr), 32'h0);
        timeoutClr = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00);
        checkOutput("t5_gnt1",  32'(aGnt),   32'h2);
        checkOutput("t5_own1",  32'(aOwner), 32'h1);

        // Asynchronous reset in the middle of a read burst.
        doReset();
        applyStimulus(2'b01, 2'b00, 2'b00);
        mAdd[31:0] = 32'h30;
        applyStimulus(2'b01, 2'b01, 2'b00);
        checkOutput("t6_busrd", 32'(aBusRd), 32'h1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t6_gnt0",  32'(aGnt),     32'h0);
        checkOutput("t6_rd0",   32'(aBusRd),   32'h0);
        checkOutput("t6_wr0",   32'(aBusWr),   32'h0);
        checkOutput("t6_rv0",   32'(aRdValid), 32'h0);
        mReq = 2'b10;
        mRd  = 2'b00;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(2'b10, 2'b00, 2'b00);
        checkOutput("t6_gnt1",  32'(aGnt),     32'h2);
        checkOutput("t6_own1",  32'(aOwner),   32'h1);
        checkOutput("t6_rv",    32'(aRdValid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
